// File: rtl/dispatch_mult_pkg.sv
// Shared CPU defines: tag/data widths, holding-register state and bundle.
// Imported by the dispatch and issue-queue blocks.
package dispatch_mult_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  rstag;
        logic [TAG_W-1:0]  rttag;
        logic [DATA_W-1:0] rsdata;
        logic [DATA_W-1:0] rtdata;
        logic              rsvalid;
        logic              rtvalid;
    } hold_t;

    // An operand still waiting on its producer picks up a matching broadcast.
    function automatic logic cdb_hit(
        input logic             valid,
        input logic [TAG_W-1:0] tag,
        input logic             bus_valid,
        input logic [TAG_W-1:0] bus_tag
    );
        return !valid && bus_valid && (tag == bus_tag);
    endfunction

endpackage

// File: rtl/dispatch_mult_tag_fifo.sv
// tag_fifo: free list of multiply destination tags.
// Ports: clk, reset, push/push_tag (returned tag), pop, head, count,
//        overflow (push dropped at full), bad_tag (push outside pool range).
module tag_fifo
    import dispatch_mult_pkg::*;
#(
    parameter logic [TAG_W-1:0] TAG_BASE   = 6'd32,
    parameter int               POOL_DEPTH = 8,
    parameter int               PTR_W      = $clog2(POOL_DEPTH),
    parameter int               CNT_W      = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             bad_tag
);

    logic [TAG_W-1:0] mem [POOL_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [TAG_W:0]   offset;
    logic             in_range;
    logic             full;
    logic             do_pop;
    logic             do_push;

    // Extra bit keeps tags below TAG_BASE from wrapping into range.
    assign offset   = {1'b0, push_tag} - {1'b0, TAG_BASE};
    assign in_range = !offset[TAG_W] && (offset < (TAG_W+1)'(POOL_DEPTH));
    assign full     = (count == CNT_W'(POOL_DEPTH));

    assign do_pop   = pop && (count != '0);
    // A same-cycle pop frees the slot a push at full needs.
    assign do_push  = push && in_range && (!full || do_pop);
    assign overflow = push && in_range && full && !do_pop;
    assign bad_tag  = push && !in_range;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < POOL_DEPTH; i++) begin
                mem[i] <= TAG_BASE + TAG_W'(i);
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= CNT_W'(POOL_DEPTH);
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dispatch_mult.sv
// dispatch_mult: one-entry holding register for multiply instructions,
// CDB snoop on waiting operands, destination tag from a free-list pool.
// Ports: decode side (in_*), CDB snoop (cdb_*), tag return (tagfree_*),
//        issue-queue side (dispatch_*), sticky pool_err.
module dispatch_mult
    import dispatch_mult_pkg::*;
#(
    parameter logic [TAG_W-1:0] TAG_BASE   = 6'd32,
    parameter int               POOL_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_en,
    input  logic [TAG_W-1:0]  in_rstag,
    input  logic [TAG_W-1:0]  in_rttag,
    input  logic [DATA_W-1:0] in_rsdata,
    input  logic [DATA_W-1:0] in_rtdata,
    input  logic              in_rsvalid,
    input  logic              in_rtvalid,
    output logic              in_ready,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              tagfree_en,
    input  logic [TAG_W-1:0]  tagfree_tag,
    output logic [TAG_W-1:0]  dispatch_rdtag,
    output logic [TAG_W-1:0]  dispatch_rstag,
    output logic [TAG_W-1:0]  dispatch_rttag,
    output logic [DATA_W-1:0] dispatch_rsdata,
    output logic [DATA_W-1:0] dispatch_rtdata,
    output logic              dispatch_rsvalid,
    output logic              dispatch_rtvalid,
    output logic              dispatch_en,
    input  logic              dispatch_ready,
    output logic              pool_err
);

    localparam int CNT_W = $clog2(POOL_DEPTH) + 1;

    hold_state_t      state;
    hold_t            hold;
    logic [CNT_W-1:0] pool_cnt;
    logic             fifo_ovf;
    logic             fifo_bad;
    logic             xfer;
    logic             accept;
    logic             rs_byp;
    logic             rt_byp;
    logic             rs_hit;
    logic             rt_hit;

    tag_fifo #(
        .TAG_BASE   (TAG_BASE),
        .POOL_DEPTH (POOL_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tagfree_en),
        .push_tag (tagfree_tag),
        .pop      (xfer),
        .head     (dispatch_rdtag),
        .count    (pool_cnt),
        .overflow (fifo_ovf),
        .bad_tag  (fifo_bad)
    );

    // No tag to hand out means the held instruction simply waits.
    assign dispatch_en = (state == FULL) && (pool_cnt != '0);
    assign xfer        = dispatch_en && dispatch_ready;
    assign in_ready    = (state == EMPTY) || xfer;
    assign accept      = in_en && in_ready;

    assign rs_byp = cdb_hit(in_rsvalid, in_rstag, cdb_valid, cdb_tag);
    assign rt_byp = cdb_hit(in_rtvalid, in_rttag, cdb_valid, cdb_tag);
    assign rs_hit = cdb_hit(hold.rsvalid, hold.rstag, cdb_valid, cdb_tag);
    assign rt_hit = cdb_hit(hold.rtvalid, hold.rttag, cdb_valid, cdb_tag);

    assign dispatch_rstag   = hold.rstag;
    assign dispatch_rttag   = hold.rttag;
    assign dispatch_rsdata  = hold.rsdata;
    assign dispatch_rtdata  = hold.rtdata;
    assign dispatch_rsvalid = hold.rsvalid;
    assign dispatch_rtvalid = hold.rtvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            hold     <= '0;
            pool_err <= 1'b0;
        end else begin
            if (fifo_ovf || fifo_bad) begin
                pool_err <= 1'b1;
            end
            if (accept) begin
                state        <= FULL;
                hold.rstag   <= in_rstag;
                hold.rttag   <= in_rttag;
                hold.rsvalid <= in_rsvalid || rs_byp;
                hold.rtvalid <= in_rtvalid || rt_byp;
                hold.rsdata  <= rs_byp ? cdb_data : in_rsdata;
                hold.rtdata  <= rt_byp ? cdb_data : in_rtdata;
            end else if (xfer) begin
                // The issue queue sees this cycle's broadcast itself.
                state <= EMPTY;
            end else if (state == FULL) begin
                if (rs_hit) begin
                    hold.rsdata  <= cdb_data;
                    hold.rsvalid <= 1'b1;
                end
                if (rt_hit) begin
                    hold.rtdata  <= cdb_data;
                    hold.rtvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatch_mult.sv
// Scoreboard bench for dispatch_mult: expected operands queued on accept,
// destination tags from a free-list model, both checked on each transfer.
module tb_dispatch_mult;
    import dispatch_mult_pkg::*;

    typedef struct packed {
        logic [5:0]  rstag;
        logic [5:0]  rttag;
        logic [31:0] rsdata;
        logic [31:0] rtdata;
        logic        rsvalid;
        logic        rtvalid;
    } op_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_en = 1'b0;
    logic [5:0]  in_rstag = '0;
    logic [5:0]  in_rttag = '0;
    logic [31:0] in_rsdata = '0;
    logic [31:0] in_rtdata = '0;
    logic        in_rsvalid = 1'b0;
    logic        in_rtvalid = 1'b0;
    logic        in_ready;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        tagfree_en = 1'b0;
    logic [5:0]  tagfree_tag = '0;
    logic [5:0]  dispatch_rdtag;
    logic [5:0]  dispatch_rstag;
    logic [5:0]  dispatch_rttag;
    logic [31:0] dispatch_rsdata;
    logic [31:0] dispatch_rtdata;
    logic        dispatch_rsvalid;
    logic        dispatch_rtvalid;
    logic        dispatch_en;
    logic        dispatch_ready = 1'b0;
    logic        pool_err;

    int checks = 0;
    int failures = 0;
    op_t        sb[$];
    logic [5:0] fl[$];

    dispatch_mult dut (
        .clk              (clk),
        .reset            (reset),
        .in_en            (in_en),
        .in_rstag         (in_rstag),
        .in_rttag         (in_rttag),
        .in_rsdata        (in_rsdata),
        .in_rtdata        (in_rtdata),
        .in_rsvalid       (in_rsvalid),
        .in_rtvalid       (in_rtvalid),
        .in_ready         (in_ready),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_data         (cdb_data),
        .tagfree_en       (tagfree_en),
        .tagfree_tag      (tagfree_tag),
        .dispatch_rdtag   (dispatch_rdtag),
        .dispatch_rstag   (dispatch_rstag),
        .dispatch_rttag   (dispatch_rttag),
        .dispatch_rsdata  (dispatch_rsdata),
        .dispatch_rtdata  (dispatch_rtdata),
        .dispatch_rsvalid (dispatch_rsvalid),
        .dispatch_rtvalid (dispatch_rtvalid),
        .dispatch_en      (dispatch_en),
        .dispatch_ready   (dispatch_ready),
        .pool_err         (pool_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: transfers happen at the posedge following this negedge.
    always @(negedge clk) begin
        logic xf;
        op_t  e;
        if (reset) begin
            sb.delete();
            fl.delete();
            for (int i = 0; i < 8; i++) fl.push_back(6'd32 + 6'(i));
        end else begin
            xf = dispatch_en && dispatch_ready;
            if (xf) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rstag", dispatch_rstag, e.rstag);
                    chk("rttag", dispatch_rttag, e.rttag);
                    chk("rsdata", dispatch_rsdata, e.rsdata);
                    chk("rtdata", dispatch_rtdata, e.rtdata);
                    chk("rsvalid", dispatch_rsvalid, e.rsvalid);
                    chk("rtvalid", dispatch_rtvalid, e.rtvalid);
                end
                if (fl.size() == 0) chk("fl_underflow", 32'd1, 32'd0);
                else chk("rdtag", dispatch_rdtag, fl.pop_front());
            end
            if (tagfree_en && tagfree_tag >= 6'd32 && tagfree_tag <= 6'd39
                && fl.size() < 8)
                fl.push_back(tagfree_tag);
        end
    end

    function automatic op_t mk(input logic [5:0] rst, rtt,
                               input logic [31:0] rsd, rtd,
                               input logic rsv, rtv);
        op_t o;
        o.rstag = rst;  o.rttag = rtt;
        o.rsdata = rsd; o.rtdata = rtd;
        o.rsvalid = rsv; o.rtvalid = rtv;
        return o;
    endfunction

    // Called and returns at posedge+1.
    task automatic send(input op_t op, input op_t exp, output int waits);
        bit done = 0;
        in_rstag = op.rstag;   in_rttag = op.rttag;
        in_rsdata = op.rsdata; in_rtdata = op.rtdata;
        in_rsvalid = op.rsvalid; in_rtvalid = op.rtvalid;
        in_en = 1'b1;
        waits = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        in_en = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        in_en = 1'b0;
        reset = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        op_t o;
        int  w;
        @(posedge clk); #1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_disp_en", dispatch_en, 0);
        chk("rst_pool_err", pool_err, 0);
        chk("rst_rdtag", dispatch_rdtag, 32);
        chk("rst_rsvalid", dispatch_rsvalid, 0);
        chk("rst_rsdata", dispatch_rsdata, 0);
        cycle();

        // Basic dispatch, tags 32 then 33
        dispatch_ready = 1'b1;
        o = mk(6'd1, 6'd2, 32'd5, 32'd7, 1, 1);
        send(o, o, w);
        @(negedge clk);
        chk("b_disp_en", dispatch_en, 1);
        chk("b_rdtag0", dispatch_rdtag, 32);
        chk("b_rsdata", dispatch_rsdata, 5);
        chk("b_rtdata", dispatch_rtdata, 7);
        cycle();
        o = mk(6'd3, 6'd4, 32'd9, 32'd11, 1, 1);
        send(o, o, w);
        @(negedge clk);
        chk("b_rdtag1", dispatch_rdtag, 33);
        cycle();
        dispatch_ready = 1'b0;

        // CDB capture while held
        send(mk(6'd12, 6'd3, 32'h1111, 32'd9, 0, 1),
             mk(6'd12, 6'd3, 32'hDEAD, 32'd9, 1, 1), w);
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'hDEAD;
        @(negedge clk);
        chk("snoop_pre", dispatch_rsvalid, 0);
        cycle();
        cdb_valid = 1'b0;
        @(negedge clk);
        chk("snoop_rsvalid", dispatch_rsvalid, 1);
        chk("snoop_rsdata", dispatch_rsdata, 32'hDEAD);
        cycle();
        dispatch_ready = 1'b1;
        cycle();
        dispatch_ready = 1'b0;

        // Same-cycle bypass on accept; unmatched rs stays waiting
        cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_data = 32'hBEEF;
        send(mk(6'd13, 6'd20, 32'h3333, 32'h2222, 0, 0),
             mk(6'd13, 6'd20, 32'h3333, 32'hBEEF, 0, 1), w);
        cdb_valid = 1'b0;
        @(negedge clk);
        chk("byp_rtvalid", dispatch_rtvalid, 1);
        chk("byp_rtdata", dispatch_rtdata, 32'hBEEF);
        chk("byp_rsvalid", dispatch_rsvalid, 0);
        cycle();
        dispatch_ready = 1'b1;
        cycle();
        dispatch_ready = 1'b0;

        // Reset while FULL takes priority over a pending accept
        o = mk(6'd1, 6'd1, 32'd1, 32'd1, 1, 1);
        send(o, o, w);
        @(negedge clk);
        chk("d_full_en", dispatch_en, 1);
        cycle();
        in_en = 1'b1;
        do_reset();
        @(negedge clk);
        chk("d_disp_en", dispatch_en, 0);
        chk("d_in_ready", in_ready, 1);
        chk("d_rdtag", dispatch_rdtag, 32);
        chk("d_rsvalid", dispatch_rsvalid, 0);
        cycle();

        // Back-to-back until the pool runs dry, then tag return
        dispatch_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            o = mk(6'(i), 6'(i + 1), 32'(100 + i), 32'(200 + i), 1, 1);
            send(o, o, w);
            chk("b2b_wait", w, 0);
        end
        repeat (2) begin
            @(negedge clk);
            chk("dry_disp_en", dispatch_en, 0);
            chk("dry_in_ready", in_ready, 0);
            cycle();
        end
        tagfree_en = 1'b1; tagfree_tag = 6'd34;
        @(negedge clk);
        chk("free_pre_en", dispatch_en, 0);
        cycle();
        tagfree_en = 1'b0;
        @(negedge clk);
        chk("free_disp_en", dispatch_en, 1);
        chk("free_rdtag", dispatch_rdtag, 34);
        cycle();
        dispatch_ready = 1'b0;
        cycle();

        // Foreign tag
        do_reset();
        tagfree_en = 1'b1; tagfree_tag = 6'd5;
        cycle();
        tagfree_en = 1'b0;
        @(negedge clk);
        chk("err_foreign", pool_err, 1);
        cycle();
        dispatch_ready = 1'b1;
        o = mk(6'd0, 6'd0, 32'd1, 32'd2, 1, 1);
        send(o, o, w);
        cycle();
        chk("err_sticky", pool_err, 1);

        // Push at full pool with no pop
        do_reset();
        dispatch_ready = 1'b0;
        tagfree_en = 1'b1; tagfree_tag = 6'd33;
        cycle();
        tagfree_en = 1'b0;
        @(negedge clk);
        chk("err_overflow", pool_err, 1);
        cycle();

        // Push and pop together at full pool: recycled tag goes to the tail
        do_reset();
        dispatch_ready = 1'b1;
        o = mk(6'd7, 6'd8, 32'd70, 32'd80, 1, 1);
        send(o, o, w);
        tagfree_en = 1'b1; tagfree_tag = 6'd32;
        cycle();
        tagfree_en = 1'b0;
        @(negedge clk);
        chk("pp_no_err", pool_err, 0);
        cycle();
        for (int i = 0; i < 8; i++) begin
            o = mk(6'(i), 6'(i), 32'(300 + i), 32'(400 + i), 1, 1);
            send(o, o, w);
        end
        @(negedge clk);
        chk("pp_last_rdtag", dispatch_rdtag, 32);
        cycle();
        repeat (2) cycle();
        dispatch_ready = 1'b0;

        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dispatch_mult.md
DISPATCH_MULT -- requirements
Module: dispatch_mult

Interface
REQ-001 SHALL have parameter TAG_BASE, default 6'd32: first tag of the multiply tag pool.
REQ-002 SHALL have parameter POOL_DEPTH, default 8: number of pool tags, power of two, at most 32.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_en  input  1  upstream decode offers a multiply instruction.
REQ-006 in_rstag, in_rttag  input  6 each  producer tags of rs and rt.
REQ-007 in_rsdata, in_rtdata  input  32 each  operand values.
REQ-008 in_rsvalid, in_rtvalid  input  1 each  operand value valid; when 0, the tag is meaningful.
REQ-009 in_ready  output  1  block can accept an instruction this cycle.
REQ-010 cdb_valid  input  1; cdb_tag  input  6; cdb_data  input  32: common data bus broadcast.
REQ-011 tagfree_en  input  1; tagfree_tag  input  6: retired multiply tag returned to the pool.
REQ-012 dispatch_rdtag, dispatch_rstag, dispatch_rttag  output  6 each  to the multiply issue queue.
REQ-013 dispatch_rsdata, dispatch_rtdata  output  32 each; dispatch_rsvalid, dispatch_rtvalid  output  1 each.
REQ-014 dispatch_en  output  1  offer valid; dispatch_ready  input  1  issue queue accepts.
REQ-015 pool_err  output  1  sticky flag: free-list overflow or foreign tag returned.

Function
REQ-016 SHALL hold one instruction in a holding register with two states, EMPTY and FULL.
REQ-017 in_ready SHALL equal (state==EMPTY) or xfer, where xfer = dispatch_en && dispatch_ready; this is combinational.
REQ-018 An accept (in_en && in_ready) SHALL load the holding register and enter or remain in FULL.
REQ-019 An xfer without an accept in the same cycle SHALL go FULL->EMPTY; an xfer with an accept SHALL stay FULL, loaded with the new instruction.
REQ-020 dispatch_en SHALL equal (state==FULL) && (pool count != 0); with an empty pool it stays 0 and the holding register stalls.
REQ-021 dispatch_rdtag SHALL be the free-list head; xfer SHALL pop it, giving 1 cycle from accept to earliest xfer.
REQ-022 dispatch_rs*/rt* fields SHALL come straight from the holding register, with no combinational CDB bypass on outputs.
REQ-023 While FULL with rsvalid=0, a broadcast with cdb_valid && cdb_tag==rstag SHALL set rsdata=cdb_data and rsvalid=1; rt SHALL be handled the same way, independently.
REQ-024 On accept, an operand with in_*valid=0 whose tag matches a same-cycle CDB broadcast SHALL load cdb_data with valid=1.
REQ-025 A CDB capture in the xfer cycle SHALL be lost; the issue queue snoops the same broadcast.
REQ-026 Free list: FIFO, POOL_DEPTH entries, count width log2(POOL_DEPTH)+1, pointers wrapping modulo POOL_DEPTH.
REQ-027 Simultaneous pop (xfer) and push (tagfree_en) SHALL both take effect, including at count 0 with no pop and at count POOL_DEPTH.
REQ-028 A push at count POOL_DEPTH without a pop in the same cycle SHALL be dropped and set pool_err.
REQ-029 A push with tagfree_tag outside [TAG_BASE, TAG_BASE+POOL_DEPTH-1] SHALL be dropped and set pool_err.
REQ-030 pool_err SHALL clear only on reset.

Reset
REQ-031 reset SHALL force state EMPTY, dispatch_en=0, in_ready=1, pool_err=0, and holding register contents to 0 including valid bits.
REQ-032 reset SHALL fill the free list with TAG_BASE+0 .. TAG_BASE+POOL_DEPTH-1 in ascending order, count POOL_DEPTH.
REQ-033 reset SHALL take priority over accept, xfer, push and CDB capture in the same cycle; a held instruction is discarded.

Structure
REQ-034 Tag width (6), data width (32) and the EMPTY/FULL state encoding SHALL live in the shared CPU defines package used by the dispatch and issue-queue blocks.
REQ-035 The free list SHALL be a sub-module, tag_fifo, with push/pop/head/count/overflow ports; the holding register and snoop logic SHALL stay in dispatch_mult.

Verification
REQ-036 Reset, then in_en with rsvalid=rtvalid=1, rs=5, rt=7, dispatch_ready=1 -> next cycle dispatch_en=1, rdtag=32, rsdata=5, rtdata=7; following offer gets rdtag=33.
REQ-037 Accept with rsvalid=0, rstag=12, dispatch_ready=0; next cycle cdb_valid, cdb_tag=12, cdb_data=0xDEAD -> following cycle dispatch_rsvalid=1, rsdata=0xDEAD.
REQ-038 Eight xfers with no tagfree -> ninth instruction held with dispatch_en=0; tagfree_tag=34 -> next cycle dispatch_en=1, rdtag=34.
REQ-039 Back-to-back in_en with dispatch_ready=1 held -> one instruction per cycle, in_ready stays 1, rdtags 32,33,34,...
REQ-040 tagfree_tag=5 -> pool_err=1, count unchanged; tagfree at full pool without pop -> pool_err=1.
REQ-041 reset asserted while FULL with dispatch_ready=0 -> next cycle dispatch_en=0, in_ready=1, head rdtag=32.
